ibus_rdata_tx: RTL
==================

IBUS_RDATA_TX -- requirements
Module: ibus_rdata_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..1023.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port rdata_valid  input  1  ibus_rdata holds a word to transmit this cycle.
REQ-005 SHALL provide port ibus_rdata  input  16  read-data word to serialize.
REQ-006 SHALL provide port rdata_ready  output  1  holding buffer empty; the word is accepted when rdata_valid & rdata_ready.
REQ-007 SHALL provide port clr_ovr  input  1  clears the overrun flag.
REQ-008 SHALL provide port tx  output  1  serial line; idles high.
REQ-009 SHALL provide port busy  output  1  FSM not in IDLE, or holding buffer full.
REQ-010 SHALL provide port overrun  output  1  sticky flag: a word was offered while rdata_ready was low.
REQ-011 SHALL provide port frames_sent  output  8  count of completed frames.

Function
REQ-012 SHALL contain a one-entry holding buffer (buf_data[15:0], buf_full), a 16-bit shift register, a bit-period counter and a 5-bit bit index.
REQ-013 SHALL drive rdata_ready = ~buf_full combinationally.
REQ-014 SHALL, on accept, load buf_data and set buf_full at that clock edge.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: tx=1. If buf_full, SHALL copy buf_data to the shift register, clear buf_full and enter START at the next edge.
REQ-017 START: SHALL hold tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-018 DATA: SHALL send 16 bits LSB first, each for exactly CLKS_PER_BIT cycles, then enter STOP.
REQ-019 STOP: SHALL hold tx=1 for exactly CLKS_PER_BIT cycles.
REQ-020 In the last STOP cycle SHALL increment frames_sent, wrapping modulo 256 (255 -> 0).
REQ-021 In the last STOP cycle with buf_full=1, SHALL load the shift register, clear buf_full and enter START directly, with no idle cycle between frames.
REQ-022 In the last STOP cycle with buf_full=0, SHALL enter IDLE.
REQ-023 Latency: accept at edge E -> FSM leaves IDLE at edge E+1 -> tx=0 from the cycle after edge E+1; a frame occupies exactly 18*CLKS_PER_BIT cycles.
REQ-024 SHALL register tx (driven from a flop); tx SHALL never glitch low in IDLE.
REQ-025 A buffer pull and a new accept in the same cycle SHALL be impossible, because ready reflects buf_full from the previous edge; the new word is accepted in the following cycle.
REQ-026 rdata_valid while rdata_ready=0 SHALL drop the word, leave buffer and frame unaffected, and set overrun at that edge.
REQ-027 clr_ovr SHALL clear overrun at the next edge; if a drop and clr_ovr occur in the same cycle, overrun SHALL be set (set wins).
REQ-028 ibus_rdata SHALL be ignored when rdata_valid=0.

Reset
REQ-029 While rst=1 at an edge: FSM=IDLE, tx=1, buf_full=0 (rdata_ready=1), busy=0, overrun=0, frames_sent=0, counters=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with tx=1 from the next cycle; the buffered word is discarded and frames_sent is not incremented.
REQ-031 rdata_valid asserted during a reset cycle SHALL NOT be accepted.

Verification (CLKS_PER_BIT=4)
REQ-032 Single frame: accept 16'hA5C3 at edge E -> tx=1 through edge E+1, then tx samples every 4 cycles = 0, bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1; frame is 72 cycles; frames_sent=1.
REQ-033 Back-to-back: accept 16'h0001, then 16'hFFFF as soon as ready -> two contiguous 72-cycle frames with no idle cycle between them; frames_sent=2; busy high throughout.
REQ-034 Overrun: with the buffer full, offer 16'h1234 -> word absent from tx and overrun=1; pulse clr_ovr -> overrun=0 next cycle; simultaneous drop and clr_ovr -> overrun=1.
REQ-035 Reset mid-frame: assert rst during DATA bit 7 for 1 cycle -> tx=1, rdata_ready=1, frames_sent=0 next cycle; a new accept afterwards produces a clean frame.
REQ-036 Wrap: send 256 frames -> frames_sent reads 0 after the 256th stop bit and 1 after the 257th.

Source files
------------

// File: rtl/ibus_rdata_tx.sv
// ibus_rdata_tx
// Serializes 16-bit instruction-bus read-data words onto a single UART-style
// line: one start bit (0), 16 data bits LSB first, one stop bit (1). Each bit
// lasts CLKS_PER_BIT clock cycles. A one-entry holding buffer lets the next
// word be accepted while the current frame is on the line, so frames can run
// back to back.
//
// Ports
//   clk          : sole clock, rising edge
//   rst          : synchronous active-high reset
//   rdata_valid  : ibus_rdata holds a word to send this cycle
//   ibus_rdata   : 16-bit word to serialize
//   rdata_ready  : holding buffer empty (word taken on valid & ready)
//   clr_ovr      : clears the overrun flag
//   tx           : registered serial line, idles high
//   busy         : frame in progress or holding buffer occupied
//   overrun      : sticky, a word was offered while the buffer was full
//   frames_sent  : completed-frame counter, wraps modulo 256
//   o_dbg_state  : current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: a word transfers on a rising edge where rdata_valid and
// rdata_ready are both high. rdata_ready depends only on registered state,
// never on rdata_valid. A word offered while rdata_ready is low is dropped
// and sets overrun; the producer is not stalled.
module ibus_rdata_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdata_valid,
  input  logic [15:0] ibus_rdata,
  output logic        rdata_ready,
  input  logic        clr_ovr,
  output logic        tx,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  frames_sent,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [9:0] LAST_CNT = 10'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic [9:0]  r_cnt;
  logic [4:0]  r_bit_idx;
  logic [15:0] r_shift;
  logic        r_tx;
  logic [15:0] r_buf_data;
  logic        r_buf_full;
  logic        r_overrun;
  logic [7:0]  r_frames;

  state_t      w_state_next;
  logic [9:0]  w_cnt_next;
  logic [4:0]  w_idx_next;
  logic [15:0] w_shift_next;
  logic        w_tx_next;
  logic        w_pull;
  logic        w_frame_done;
  logic        w_bit_end;
  logic        w_accept;
  logic        w_drop;

  // Accept and drop both look at the buffer state from the previous edge, so a
  // pull and an accept can never land on the same edge.
  assign w_accept  = rdata_valid & ~r_buf_full;
  assign w_drop    = rdata_valid & r_buf_full;
  assign w_bit_end = (r_cnt == LAST_CNT);

  // tx is registered from the value the line must carry in the NEXT state, so
  // the line changes on the same edge as the state and never glitches.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pull       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_next  = 1'b1;
        w_cnt_next = '0;
        if (r_buf_full) begin
          w_pull       = 1'b1;
          w_shift_next = r_buf_data;
          w_state_next = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = S_DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_cnt_next = r_cnt + 10'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_bit_idx == 5'd15) begin
            w_state_next = S_STOP;
            w_tx_next    = 1'b1;
          end else begin
            // r_shift[0] is the bit now on the line; [1] is the next one.
            w_idx_next   = r_bit_idx + 5'd1;
            w_shift_next = {1'b0, r_shift[15:1]};
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt + 10'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_frame_done = 1'b1;
          if (r_buf_full) begin
            // Chain straight into the next start bit, no idle cycle.
            w_pull       = 1'b1;
            w_shift_next = r_buf_data;
            w_state_next = S_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = S_IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 10'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_buf_data <= '0;
      r_buf_full <= 1'b0;
      r_overrun  <= 1'b0;
      r_frames   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      if (w_pull) begin
        r_buf_full <= 1'b0;
      end else if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf_data <= ibus_rdata;
      end
      // A drop in the same cycle as clr_ovr leaves the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_done) begin
        r_frames <= r_frames + 8'd1;
      end
    end
  end

  assign rdata_ready = ~r_buf_full;
  assign tx          = r_tx;
  assign busy        = (r_state != S_IDLE) | r_buf_full;
  assign overrun     = r_overrun;
  assign frames_sent = r_frames;
  assign o_dbg_state = r_state;

endmodule
